// File: rtl/beam_summer.sv
// ---------------------------------------------------------------------------
// beam_summer
//
// Delay-and-sum beamformer back end. On a sample_valid strobe the eight
// already-delayed microphone samples and the channel mask are captured. The
// selected channels are then summed one per cycle into a 22-bit signed
// accumulator. The scaled result is registered onto sum_data with a
// one-cycle sum_valid strobe. Capture to sum_valid takes 9 clock edges, so
// samples may arrive every 10 cycles. A strobe that arrives while a sum is in
// progress is dropped and latches the sticky overrun flag.
//
// Configuration macro:
//   BEAM_SUM_SAT_EN  defined   : sum_data = accumulator saturated to the
//                                19-bit signed range (gain 8)
//                    undefined : sum_data = accumulator >>> 3 (floor),
//                                i.e. the mean of 8 channels
//
// Ports:
//   clk                 in   single clock, rising edge
//   rst                 in   asynchronous reset, active low
//   sample_valid        in   one-cycle strobe, new samples on ch_data_*
//   ch_data_0..7 [18:0] in   signed delayed PCM per microphone
//   ch_mask      [7:0]  in   bit i = 1 includes channel i in the sum
//   sum_data     [18:0] out  signed beamformed sample, registered, held
//   sum_valid           out  one-cycle strobe qualifying sum_data
//   busy                out  high while accumulating or finishing
//   overrun             out  sticky: a sample_valid was dropped
// ---------------------------------------------------------------------------
module beam_summer #(
  parameter int DATA_W = 19,
  parameter int ACC_W  = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] ch_data_0,
  input  logic signed [DATA_W-1:0] ch_data_1,
  input  logic signed [DATA_W-1:0] ch_data_2,
  input  logic signed [DATA_W-1:0] ch_data_3,
  input  logic signed [DATA_W-1:0] ch_data_4,
  input  logic signed [DATA_W-1:0] ch_data_5,
  input  logic signed [DATA_W-1:0] ch_data_6,
  input  logic signed [DATA_W-1:0] ch_data_7,
  input  logic [7:0]               ch_mask,
  output logic signed [DATA_W-1:0] sum_data,
  output logic                     sum_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]               state;
  logic [2:0]               idx;
  logic signed [DATA_W-1:0] ch_in [8];
  logic signed [DATA_W-1:0] ch_p0 [8];
  logic [7:0]               mask_p0;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [ACC_W-1:0]  term_p1;
  logic                     capture;

`ifdef BEAM_SUM_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((longint'(1) <<< (DATA_W-1)) - longint'(1));
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    ACC_W'(-(longint'(1) <<< (DATA_W-1)));

  // Full-scale output (gain 8): clamp the accumulator to the output range.
  function automatic logic signed [DATA_W-1:0] scale_out(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0] c;
    if (a > SAT_MAX)      c = SAT_MAX;
    else if (a < SAT_MIN) c = SAT_MIN;
    else                  c = a;
    return c[DATA_W-1:0];
  endfunction
`else
  // Mean of eight: arithmetic shift floors toward minus infinity. The sum of
  // eight 19-bit values shifted by 3 always fits back into 19 bits.
  function automatic logic signed [DATA_W-1:0] scale_out(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0] s;
    s = a >>> 3;
    return s[DATA_W-1:0];
  endfunction
`endif

  assign ch_in[0] = ch_data_0;
  assign ch_in[1] = ch_data_1;
  assign ch_in[2] = ch_data_2;
  assign ch_in[3] = ch_data_3;
  assign ch_in[4] = ch_data_4;
  assign ch_in[5] = ch_data_5;
  assign ch_in[6] = ch_data_6;
  assign ch_in[7] = ch_data_7;

  assign capture = (state == S_IDLE) && sample_valid;
  assign busy    = (state == S_ACCUM) || (state == S_DONE);

  // Sign-extended channel selected by the walking index.
  assign term_p1 = {{(ACC_W-DATA_W){ch_p0[idx][DATA_W-1]}}, ch_p0[idx]};

  // ---- stage p0: sample capture (data only, no reset needed) ----
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < 8; i++) begin
        ch_p0[i] <= ch_in[i];
      end
    end
  end

  // ---- stage p1: serial accumulation, stage p2: scaled output ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= 3'd0;
      mask_p0   <= 8'd0;
      acc_p1    <= '0;
      sum_data  <= '0;
      sum_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sample_valid) begin
            mask_p0 <= ch_mask;
            acc_p1  <= '0;
            idx     <= 3'd0;
            state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (mask_p0[idx]) begin
            acc_p1 <= acc_p1 + term_p1;
          end
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          sum_data  <= scale_out(acc_p1);
          sum_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      // A strobe while busy is dropped; the sum in progress is untouched.
      if (sample_valid && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_beam_summer.sv
// ---------------------------------------------------------------------------
// tb_beam_summer
//
// Self-checking bench for beam_summer. Directed cases cover reset, latency,
// scaling corners, empty mask, overrun, mid-sum reset and back-to-back
// samples; a randomized loop is checked against a sum-of-masked-channels
// reference model. Build with or without +define+BEAM_SUM_SAT_EN.
// ---------------------------------------------------------------------------
module tb_beam_summer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [18:0] cd [8];
  logic [7:0]         ch_mask = 8'd0;
  logic signed [18:0] sum_data;
  logic               sum_valid;
  logic               busy;
  logic               overrun;

  int         chv [8];
  logic [7:0] maskv;
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         pulses;

`ifdef BEAM_SUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  beam_summer dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .ch_data_0    (cd[0]),
    .ch_data_1    (cd[1]),
    .ch_data_2    (cd[2]),
    .ch_data_3    (cd[3]),
    .ch_data_4    (cd[4]),
    .ch_data_5    (cd[5]),
    .ch_data_6    (cd[6]),
    .ch_data_7    (cd[7]),
    .ch_mask      (ch_mask),
    .sum_data     (sum_data),
    .sum_valid    (sum_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Reference: plain integer sum of the selected channels, then either the
  // floor of the mean of eight or a clamp to the 19-bit signed range.
  function automatic int model();
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      if (maskv[i]) s += chv[i];
    end
    if (SAT) begin
      if (s > 262143)  s = 262143;
      if (s < -262144) s = -262144;
    end else begin
      s = (s >= 0) ? (s / 8) : -((-s + 7) / 8);
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic set_all(input int v, input logic [7:0] m);
    for (int i = 0; i < 8; i++) chv[i] = v;
    maskv = m;
  endtask

  task automatic scramble();
    for (int i = 0; i < 8; i++) cd[i] = 19'($urandom);
    ch_mask = 8'($urandom);
  endtask

  // Presents chv/maskv for one edge, then corrupts the inputs so that any
  // use of live inputs after the capture edge shows up in the result.
  task automatic start_sample(input string tag);
    for (int i = 0; i < 8; i++) cd[i] = chv[i][18:0];
    ch_mask = maskv;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    scramble();
    check({tag, "_busy"}, busy, 1);
  endtask

  // Counts edges from capture to sum_valid; optionally fires an extra
  // strobe sampled on edge dup_at+1.
  task automatic wait_result(input string tag, input int exp, input int dup_at);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 15) begin
      if (lat == dup_at) sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      lat++;
      if (sum_valid === 1'b1) seen = 1'b1;
    end
    check({tag, "_latency"}, lat, 9);
    check({tag, "_data"}, sum_data, exp);
  endtask

  task automatic check_hold(input string tag, input int exp);
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, sum_valid, 0);
    check({tag, "_hold"}, sum_data, exp);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic count_pulses(input int cycles);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (sum_valid === 1'b1) pulses++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp;
    for (int i = 0; i < 8; i++) cd[i] = '0;

    // Reset state
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_sum_data", sum_data, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // First strobe after reset is taken on the next edge
    set_all(1000, 8'hFF);
    start_sample("c1000");
    wait_result("c1000", SAT ? 8000 : 1000, -1);
    check_hold("c1000", SAT ? 8000 : 1000);

    set_all(200000, 8'hFF);
    start_sample("pos_big");
    wait_result("pos_big", SAT ? 262143 : 200000, -1);

    set_all(-200000, 8'hFF);
    start_sample("neg_big");
    wait_result("neg_big", SAT ? -262144 : -200000, -1);
    check_hold("neg_big", SAT ? -262144 : -200000);

    set_all(0, 8'hFF);
    chv[0] = -1;
    start_sample("minus1");
    wait_result("minus1", -1, -1);

    set_all(0, 8'h01);
    chv[0] = 800;
    chv[3] = 5000;
    start_sample("mask01");
    wait_result("mask01", SAT ? 800 : 100, -1);

    set_all(123456, 8'h00);
    start_sample("mask00");
    wait_result("mask00", 0, -1);
    check_hold("mask00", 0);

    // Back-to-back at the minimum spacing of 10 cycles
    set_all(16, 8'hFF);
    start_sample("b2b_a");
    wait_result("b2b_a", SAT ? 128 : 16, -1);
    set_all(-16, 8'hFF);
    start_sample("b2b_b");
    wait_result("b2b_b", SAT ? -128 : -16, -1);
    check("b2b_overrun", overrun, 0);

    // Randomized samples against the reference model
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 8; i++) begin
        if (n % 4 == 3) chv[i] = ($urandom_range(1) == 1) ? 262143 : -262144;
        else            chv[i] = int'($urandom_range(524287)) - 262144;
      end
      maskv = 8'($urandom);
      exp = model();
      start_sample($sformatf("rnd%0d", n));
      wait_result($sformatf("rnd%0d", n), exp, -1);
      if (n % 3 == 0) check_hold($sformatf("rnd%0d", n), exp);
    end
    check("rnd_overrun", overrun, 0);

    // Strobe 4 cycles into a sum: dropped, flagged, sum unaffected
    set_all(1000, 8'hFF);
    start_sample("ovr");
    wait_result("ovr", SAT ? 8000 : 1000, 3);
    check("ovr_flag", overrun, 1);
    count_pulses(12);
    check("ovr_extra_pulses", pulses, 0);
    check("ovr_sticky", overrun, 1);

    // Reset during the third accumulate cycle aborts the sum
    set_all(50, 8'hFF);
    start_sample("abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_sum_data", sum_data, 0);
    check("abort_sum_valid", sum_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_overrun", overrun, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    count_pulses(12);
    check("abort_no_pulse", pulses, 0);

    set_all(8, 8'hFF);
    start_sample("after_abort");
    wait_result("after_abort", SAT ? 64 : 8, -1);
    check_hold("after_abort", SAT ? 64 : 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
